instr_fetch_decode: RTL and testbench
=====================================

Name: instr_fetch_decode

Overview:
- Per-thread instruction fetch and decode stage. Sits directly upstream of the functional unit.
- On a start pulse it loads a starting PC, then fetches 32-bit instruction words from instruction memory over a req/valid handshake.
- It decodes each word into the functional unit's operation fields (type_instruction, regnum_1, regnum_2, dest_reg, shammt) and issues them with a valid/ready handshake.
- It stops on HALT and reports done plus the count of issued instructions.

Parameters:
- PC_STEP, 4, byte increment applied to the PC after each issued non-HALT instruction.
- CNT_WIDTH, 16, width of the issued-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a thread. Honoured only in IDLE or DONE.
- starting_pc  input  32  PC captured on an accepted start.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  32  fetch address; always equals the current pc.
- imem_rdata  input  32  fetched instruction word.
- imem_valid  input  1  imem_rdata valid; sampled only in FETCH.
- fu_ready  input  1  downstream accepts the issued fields this cycle.
- instr_valid  output  1  decoded fields valid.
- type_instruction  output  3  decoded operation: 000 ADD, 001 SUB, 010 MUL, 011 UDIV, 100 FADD, 101 FSUB, 111 HALT.
- regnum_1  output  5  source register 1.
- regnum_2  output  5  source register 2.
- dest_reg  output  5  destination register.
- shammt  output  6  shift amount field.
- busy  output  1  high in FETCH or ISSUE.
- done  output  1  high in DONE.
- illegal_op  output  1  sticky; set when an undefined opcode is decoded.
- instr_count  output  CNT_WIDTH  number of completed issue handshakes since the last accepted start, HALT included.

Behaviour:
- Reset (asynchronous, any state, including mid-fetch or mid-issue):
  - state = IDLE; pc = 0.
  - All outputs 0: imem_req, imem_addr, instr_valid, all decoded fields, busy, done, illegal_op, instr_count.
  - A fetch response arriving after reset is ignored.
- Instruction word format:
  - [31:26] opcode; [25:21] dest_reg; [20:16] regnum_1; [15:11] regnum_2; [10:5] shammt; [4:0] ignored.
- Opcode map:
  - 0x00 → 000; 0x01 → 001; 0x02 → 010; 0x03 → 011; 0x10 → 100; 0x11 → 101; 0x3F → 111.
  - Any other opcode: type_instruction = 111 (treated as HALT), illegal_op set.
  - Code 110 is never produced.
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE:
  - On start: pc ← starting_pc, instr_count ← 0, illegal_op ← 0, go to FETCH.
- FETCH:
  - imem_req = 1 and imem_addr = pc, held until imem_valid.
  - If imem_valid is sampled high on edge N, decoded fields register on edge N and instr_valid = 1 from cycle N+1; state → ISSUE.
  - Minimum fetch-to-issue latency is 1 cycle. A response in the same cycle as the request is accepted.
  - imem_req = 0 in all other states.
- ISSUE:
  - instr_valid = 1. Fields are held stable until the cycle in which fu_ready = 1.
  - On handshake: instr_count increments (wraps at 2^CNT_WIDTH) and instr_valid drops the next cycle.
  - If the issued type is 111: go to DONE, pc unchanged.
  - Otherwise: pc ← pc + PC_STEP (mod 2^32, so 0xFFFFFFFC wraps to 0x00000000), go to FETCH.
- DONE:
  - done = 1; instr_count and illegal_op held.
  - On start: behaves as in IDLE (captures new pc, clears count and illegal_op, goes to FETCH; done drops the next cycle).
- Start while busy (FETCH or ISSUE) is ignored. pc, count and the in-flight fetch are unaffected.
- imem_valid in IDLE, ISSUE or DONE is ignored; no state change.
- Back-to-back throughput: at most one instruction every 2 cycles (a fetch cycle, then an issue cycle) when memory and fu_ready are both immediate.

Test Plan:
- Reset, then start with starting_pc=0x100 and a memory returning {0x00: ADD r3=r1+r2, 0x3F HALT}, fu_ready=1 → imem_addr 0x100 then 0x104; issues type 000 with dest 3, rs1 1, rs2 2, then 111; done=1, instr_count=2, pc held at 0x104.
- fu_ready held low 5 cycles during ISSUE of FSUB (opcode 0x11, rd 7) → instr_valid stays 1 and fields stay constant at 101/7 for all 5 cycles; exactly one count increment after fu_ready rises.
- Opcode 0x05 fetched → type_instruction=111, illegal_op=1, DONE. A subsequent start with starting_pc=0x0 → illegal_op=0, instr_count=0, fetch from 0x0.
- starting_pc=0xFFFFFFFC holding MUL, then HALT at 0x0 → second imem_addr = 0x00000000; MUL issued as type 010, then HALT; count=2.
- imem_valid delayed 3 cycles: start pulse asserted during FETCH is ignored (pc unchanged); stray imem_valid pulse asserted in DONE causes no state change.
- rst asserted while in ISSUE with instr_valid=1 → all outputs 0 asynchronously; state IDLE; no fetch resumes until the next start.

Source files
------------

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: per-thread instruction fetch and decode stage feeding the functional unit
module instr_fetch_decode #(
    parameter int PC_STEP   = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          starting_pc,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic [31:0]          imem_rdata,
    input  logic                 imem_valid,
    input  logic                 fu_ready,
    output logic                 instr_valid,
    output logic [2:0]           type_instruction,
    output logic [4:0]           regnum_1,
    output logic [4:0]           regnum_2,
    output logic [4:0]           dest_reg,
    output logic [5:0]           shammt,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] instr_count
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

    state_t               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [2:0]           type_q, type_d;
    logic [4:0]           rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [5:0]           sh_q, sh_d;
    logic                 ill_q, ill_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           dec_type;
    logic                 dec_ill;
    logic                 unused_bits;

    assign unused_bits = ^imem_rdata[4:0];

    // opcode to operation code; anything unmapped is treated as HALT and flagged
    always_comb begin
        dec_type = 3'b111;
        dec_ill  = 1'b0;
        case (imem_rdata[31:26])
            6'h00:   dec_type = 3'b000;
            6'h01:   dec_type = 3'b001;
            6'h02:   dec_type = 3'b010;
            6'h03:   dec_type = 3'b011;
            6'h10:   dec_type = 3'b100;
            6'h11:   dec_type = 3'b101;
            6'h3F:   dec_type = 3'b111;
            default: dec_ill  = 1'b1;
        endcase
    end

    // next state: start capture, fetch acceptance and issue handshake
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        type_d  = type_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        sh_d    = sh_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                pc_d    = starting_pc;
                cnt_d   = '0;
                ill_d   = 1'b0;
                state_d = FETCH;
            end
            FETCH: if (imem_valid) begin
                type_d  = dec_type;
                rd_d    = imem_rdata[25:21];
                rs1_d   = imem_rdata[20:16];
                rs2_d   = imem_rdata[15:11];
                sh_d    = imem_rdata[10:5];
                ill_d   = ill_q | dec_ill;
                state_d = ISSUE;
            end
            ISSUE: if (fu_ready) begin
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                state_d = (type_q == 3'b111) ? DONE : FETCH;
                pc_d    = (type_q == 3'b111) ? pc_q : pc_q + 32'(PC_STEP);
            end
            default: state_d = IDLE;
        endcase
    end

    // state register; reset returns to IDLE with every output zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            type_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            sh_q    <= '0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            type_q  <= type_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            sh_q    <= sh_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req         = (state_q == FETCH);
    assign imem_addr        = pc_q;
    assign instr_valid      = (state_q == ISSUE);
    assign type_instruction = type_q;
    assign regnum_1         = rs1_q;
    assign regnum_2         = rs2_q;
    assign dest_reg         = rd_q;
    assign shammt           = sh_q;
    assign busy             = (state_q == FETCH) || (state_q == ISSUE);
    assign done             = (state_q == DONE);
    assign illegal_op       = ill_q;
    assign instr_count      = cnt_q;
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: randomized scoreboard bench for the fetch/decode stage
module tb_instr_fetch_decode;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, imem_valid = 1'b0, fu_ready = 1'b0;
    logic [31:0] starting_pc = '0, imem_rdata = '0;
    logic        imem_req, instr_valid, busy, done, illegal_op;
    logic [31:0] imem_addr;
    logic [2:0]  type_instruction;
    logic [4:0]  regnum_1, regnum_2, dest_reg;
    logic [5:0]  shammt;
    logic [15:0] instr_count;

    instr_fetch_decode dut (
        .clk(clk), .rst(rst), .start(start), .starting_pc(starting_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid), .fu_ready(fu_ready), .instr_valid(instr_valid),
        .type_instruction(type_instruction), .regnum_1(regnum_1), .regnum_2(regnum_2),
        .dest_reg(dest_reg), .shammt(shammt), .busy(busy), .done(done),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int          errors = 0, checks = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] prog [$];
    logic [55:0] sb [$];
    int          opmap [int];
    logic [5:0]  legal_ops [6] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h10, 6'h11};
    int          exp_cnt;
    logic        exp_ill;
    logic [31:0] exp_pc;
    int          lat = 0, wait_cnt = 0, rdy_mode = 1;
    bit          lat_rand = 1'b0, stray = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [5:0] sh);
        return {op, rd, rs1, rs2, sh, 5'($urandom)};
    endfunction

    // reference: walk memory from the start PC, issuing each word until a halting type
    task automatic expect_prog(input logic [31:0] spc);
        logic [31:0] pc;
        logic [31:0] w;
        int          op, ty;
        pc = spc;
        exp_cnt = 0;
        exp_ill = 1'b0;
        for (int i = 0; i < 64; i++) begin
            w  = mem.exists(pc) ? mem[pc] : 32'hFC00_0000;
            op = int'(w[31:26]);
            ty = opmap.exists(op) ? opmap[op] : 7;
            if (!opmap.exists(op)) exp_ill = 1'b1;
            sb.push_back({pc, 3'(ty), w[25:21], w[20:16], w[15:11], w[10:5]});
            exp_cnt++;
            if (ty == 7) break;
            pc = pc + 32'd4;
        end
        exp_pc = pc;
    endtask

    task automatic pulse(input logic [31:0] spc);
        @(posedge clk); #1;
        starting_pc = spc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic launch(input logic [31:0] spc);
        mem.delete();
        foreach (prog[i]) mem[spc + 32'(i * 4)] = prog[i];
        expect_prog(spc);
        pulse(spc);
    endtask

    task automatic finish_prog(input string tag);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 3000) chk({tag, "_done_timeout"}, 0, 1);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_count"}, instr_count, 16'(exp_cnt));
        chk({tag, "_illegal"}, illegal_op, exp_ill);
        chk({tag, "_pc_held"}, imem_addr, exp_pc);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!instr_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk({tag, "_valid_timeout"}, 0, 1);
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_fields"}, {type_instruction, regnum_1, regnum_2, dest_reg, shammt}, 0);
        chk({tag, "_ctrl"}, {imem_req, instr_valid, busy, done, illegal_op, instr_count}, 0);
    endtask

    // instruction memory: answers a pending request after lat cycles, or injects a stray valid
    initial forever begin
        @(posedge clk); #1;
        if (stray) begin
            imem_valid = 1'b1;
            imem_rdata = $urandom();
        end else if (!imem_req) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom();
            wait_cnt   = lat_rand ? $urandom_range(0, 3) : lat;
        end else if (wait_cnt == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem.exists(imem_addr) ? mem[imem_addr] : 32'hFC00_0000;
        end else begin
            wait_cnt--;
            imem_valid = 1'b0;
            imem_rdata = $urandom();
        end
    end

    // downstream ready: random, always high, or held low
    initial forever begin
        @(posedge clk); #1;
        fu_ready = (rdy_mode == 0) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end

    logic [55:0] cur, prev;
    bit          have_prev = 1'b0, prev_acc = 1'b0;

    // monitor: every handshake pops the scoreboard; a stalled issue must hold its fields
    always @(negedge clk) begin
        if (instr_valid) begin
            cur = {imem_addr, type_instruction, dest_reg, regnum_1, regnum_2, shammt};
            if (have_prev && !prev_acc) chk("hold_stable", cur, prev);
            if (fu_ready) begin
                if (sb.size() == 0) chk("unexpected_issue", 1, 0);
                else chk("issue", cur, sb.pop_front());
            end
            prev      = cur;
            prev_acc  = fu_ready;
            have_prev = 1'b1;
        end else begin
            have_prev = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] spc;
        logic [5:0]  op;
        opmap[0] = 0; opmap[1] = 1; opmap[2] = 2; opmap[3] = 3;
        opmap[16] = 4; opmap[17] = 5; opmap[63] = 7;

        repeat (3) @(posedge clk);
        #1;
        rst_checks("reset");
        rst = 1'b0;

        prog.delete();
        prog.push_back(mk(6'h00, 5'd3, 5'd1, 5'd2, 6'd0));
        prog.push_back(mk(6'h3F, 5'd0, 5'd0, 5'd0, 6'd0));
        launch(32'h100);
        finish_prog("add_halt");

        rdy_mode = 2;
        prog.delete();
        prog.push_back(mk(6'h11, 5'd7, 5'd4, 5'd5, 6'd9));
        prog.push_back(mk(6'h3F, 5'd0, 5'd0, 5'd0, 6'd0));
        launch(32'h400);
        wait_valid("fsub");
        repeat (5) begin
            @(negedge clk);
            chk("fsub_stall", {instr_valid, type_instruction, dest_reg, instr_count}, {1'b1, 3'b101, 5'd7, 16'd0});
        end
        rdy_mode = 1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("fsub_one_inc", instr_count, 1);
        finish_prog("fsub");

        prog.delete();
        prog.push_back(mk(6'h05, 5'd1, 5'd2, 5'd3, 6'd4));
        launch(32'h500);
        finish_prog("illegal");
        chk("illegal_type", type_instruction, 3'b111);
        prog.delete();
        prog.push_back(mk(6'h3F, 5'd0, 5'd0, 5'd0, 6'd0));
        launch(32'h0);
        chk("restart_clear", {illegal_op, instr_count, imem_addr}, 0);
        finish_prog("restart");

        prog.delete();
        prog.push_back(mk(6'h02, 5'd9, 5'd10, 5'd11, 6'd12));
        prog.push_back(mk(6'h3F, 5'd0, 5'd0, 5'd0, 6'd0));
        launch(32'hFFFF_FFFC);
        finish_prog("wrap");

        lat = 3;
        prog.delete();
        prog.push_back(mk(6'h01, 5'd2, 5'd3, 5'd4, 6'd5));
        prog.push_back(mk(6'h3F, 5'd0, 5'd0, 5'd0, 6'd0));
        launch(32'h200);
        pulse(32'h9990_0000);
        chk("busy_start_ignored", imem_addr, 32'h200);
        finish_prog("slow_mem");
        @(posedge clk); #1;
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        @(posedge clk); #1;
        chk("stray_valid", {done, busy, imem_req, instr_count}, {3'b100, 16'd2});
        lat = 0;

        rdy_mode = 2;
        prog.delete();
        prog.push_back(mk(6'h00, 5'd3, 5'd1, 5'd2, 6'd7));
        prog.push_back(mk(6'h3F, 5'd0, 5'd0, 5'd0, 6'd0));
        launch(32'h300);
        wait_valid("mid_rst");
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        rst_checks("async_rst");
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_mode = 1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_after_rst", {imem_req, busy, done, instr_valid}, 0);
        end

        lat_rand = 1'b1;
        rdy_mode = 0;
        for (int t = 0; t < 25; t++) begin
            n   = $urandom_range(0, 7);
            spc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
            prog.delete();
            for (int i = 0; i < n; i++)
                prog.push_back(mk(legal_ops[$urandom_range(0, 5)], 5'($urandom), 5'($urandom),
                                  5'($urandom), 6'($urandom)));
            if ($urandom_range(0, 2) == 0) begin
                do op = 6'($urandom_range(0, 63)); while (opmap.exists(int'(op)));
            end else begin
                op = 6'h3F;
            end
            prog.push_back(mk(op, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom)));
            launch(spc);
            finish_prog("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
